collision_detect: RTL

Produces the per-axis `collision[3:0]` code consumed by the ball position integrator. Once per update `tick`, it checks the ball's bounding box against the four board walls, then scans an external obstacle table one entry per cycle. It registers a push/freeze code for each axis. An optional hold stage keeps a code asserted for several ticks so the ball can escape an obstacle before normal motion resumes.

---
 rtl/collision_detect.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/collision_detect.sv
// collision_detect: per-axis wall/obstacle push/freeze code for the ball position integrator.
// Latency: tick sampled at edge 0; collision and done update at edge NUM_OBS+2.
// Backpressure: none; a tick arriving while busy is dropped, never queued.
// Ports: clk, rst (synchronous, active-high), tick, position_x/y (unsigned), velocity_x/y
//   (two's complement) in; obs_addr out / obs_data in (table read, data valid one cycle later);
//   collision[3:0] ({y code, x code}), busy, done out.
// Build option: define COLLIDE_HOLD_EN to hold each axis code for HOLD_TICKS ticks after
//   its last detection; without it collision is just the latest scan result.
module collision_detect #(
  parameter int BOARD_W    = 640,
  parameter int BOARD_H    = 480,
  parameter int BALL_R     = 8,
  parameter int NUM_OBS    = 8,
  parameter int HOLD_TICKS = 4,
  localparam int AW        = $clog2(NUM_OBS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tick,
  input  logic [10:0]   position_x,
  input  logic [10:0]   position_y,
  input  logic [10:0]   velocity_x,
  input  logic [10:0]   velocity_y,
  output logic [AW-1:0] obs_addr,
  input  logic [43:0]   obs_data,
  output logic [3:0]    collision,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {IDLE, WALL, SCAN, RESOLVE} state_t;

  typedef struct packed {
    logic        ovl;  // box overlaps [a0,a1] on this axis
    logic [1:0]  dir;  // push code if this axis is chosen
    logic [11:0] pen;  // penetration depth
  } axis_t;

  localparam logic [11:0] R12  = 12'(BALL_R);
  localparam logic [11:0] XMAX = 12'(BOARD_W - 1);
  localparam logic [11:0] YMAX = 12'(BOARD_H - 1);

  if (NUM_OBS < 2 || NUM_OBS > 64 || (NUM_OBS & (NUM_OBS - 1)) != 0 || HOLD_TICKS < 1)
  begin : g_bad_cfg
    $error("collision_detect: NUM_OBS must be a power of two in 2..64, HOLD_TICKS >= 1");
  end

  state_t          state_q, state_d;
  logic [10:0]     px_q, px_d, py_q, py_d;
  logic [10:0]     vx_q, vx_d, vy_q, vy_d;
  logic [AW-1:0]   k_q, k_d;
  logic [1:0]      fx_q, fx_d, fy_q, fy_d;
  logic [1:0][1:0] coll_q, coll_d;
  logic            done_q, done_d;

  // ---------------------------------------------------------------------------
  // Wall test on the latched position/velocity.
  // ---------------------------------------------------------------------------
  logic [11:0] px12, py12;
  logic [1:0]  wall_fx, wall_fy;

  assign px12 = {1'b0, px_q};
  assign py12 = {1'b0, py_q};

  always_comb begin
    wall_fx = 2'b00;
    wall_fy = 2'b00;
    if (px12 <= R12 && vx_q[10])                 wall_fx = wall_fx | 2'b10;
    if (px12 + R12 >= XMAX && !vx_q[10] && |vx_q) wall_fx = wall_fx | 2'b01;
    if (py12 <= R12 && vy_q[10])                 wall_fy = wall_fy | 2'b10;
    if (py12 + R12 >= YMAX && !vy_q[10] && |vy_q) wall_fy = wall_fy | 2'b01;
  end

  // ---------------------------------------------------------------------------
  // Obstacle test for the entry currently on obs_data (12-bit unsigned math).
  // ---------------------------------------------------------------------------
  function automatic axis_t axis_eval(input logic [10:0] p, input logic [10:0] a0,
                                      input logic [10:0] a1);
    axis_t       r;
    logic [11:0] p12, b0, b1, lo, hi, lo_edge, hi_edge, mid;
    p12     = {1'b0, p};
    b0      = {1'b0, a0};
    b1      = {1'b0, a1};
    lo      = (p12 >= R12) ? p12 - R12 : 12'd0;  // clamp at the board origin
    hi      = p12 + R12;
    hi_edge = (hi < b1) ? hi : b1;
    lo_edge = (lo > b0) ? lo : b0;
    mid     = (b0 + b1) >> 1;
    r.ovl   = (hi >= b0) && (lo <= b1);
    r.pen   = hi_edge - lo_edge;
    r.dir   = (p12 < mid) ? 2'b01 : 2'b10;
    return r;
  endfunction

  axis_t      ex, ey;
  logic       obs_hit;
  logic [1:0] obs_fx, obs_fy;

  assign ex      = axis_eval(px_q, obs_data[43:33], obs_data[21:11]);
  assign ey      = axis_eval(py_q, obs_data[32:22], obs_data[10:0]);
  assign obs_hit = (obs_data[43:33] <= obs_data[21:11]) && ex.ovl && ey.ovl;

  // Shallower axis wins; an exact tie flags both axes.
  always_comb begin
    obs_fx = 2'b00;
    obs_fy = 2'b00;
    if (obs_hit) begin
      if (ex.pen <= ey.pen) obs_fx = ex.dir;
      if (ey.pen <= ex.pen) obs_fy = ey.dir;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      px_q    <= '0;
      py_q    <= '0;
      vx_q    <= '0;
      vy_q    <= '0;
      k_q     <= '0;
      fx_q    <= '0;
      fy_q    <= '0;
      coll_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      px_q    <= px_d;
      py_q    <= py_d;
      vx_q    <= vx_d;
      vy_q    <= vy_d;
      k_q     <= k_d;
      fx_q    <= fx_d;
      fy_q    <= fy_d;
      coll_q  <= coll_d;
      done_q  <= done_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (tick) state_d = WALL;
      WALL:    state_d = SCAN;
      SCAN:    if (k_q == AW'(NUM_OBS - 1)) state_d = RESOLVE;
      RESOLVE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: datapath / output logic
  // ---------------------------------------------------------------------------
  logic [1:0][1:0] res;
  assign res = {fy_q, fx_q};

`ifdef COLLIDE_HOLD_EN
  localparam int          HW       = $clog2(HOLD_TICKS + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_TICKS);
  logic [1:0][HW-1:0] hold_q, hold_d;

  always_ff @(posedge clk) begin
    if (rst) hold_q <= '0;
    else     hold_q <= hold_d;
  end
`endif

  always_comb begin
    px_d   = px_q;
    py_d   = py_q;
    vx_d   = vx_q;
    vy_d   = vy_q;
    k_d    = k_q;
    fx_d   = fx_q;
    fy_d   = fy_q;
    coll_d = coll_q;
    done_d = 1'b0;
`ifdef COLLIDE_HOLD_EN
    hold_d = hold_q;
`endif
    case (state_q)
      IDLE: begin
        if (tick) begin
          px_d = position_x;
          py_d = position_y;
          vx_d = velocity_x;
          vy_d = velocity_y;
          fx_d = 2'b00;
          fy_d = 2'b00;
        end
      end
      WALL: begin
        fx_d = fx_q | wall_fx;
        fy_d = fy_q | wall_fy;
        k_d  = '0;
      end
      SCAN: begin
        // Opposing pushes on one axis OR together into 11 (freeze).
        fx_d = fx_q | obs_fx;
        fy_d = fy_q | obs_fy;
        k_d  = k_q + AW'(1);
      end
      RESOLVE: begin
        done_d = 1'b1;
`ifdef COLLIDE_HOLD_EN
        for (int a = 0; a < 2; a++) begin
          if (res[a] != 2'b00) begin
            coll_d[a] = res[a];
            hold_d[a] = HOLD_MAX;
          end else if (hold_q[a] != '0) begin
            hold_d[a] = hold_q[a] - HW'(1);  // keep previous code
          end else begin
            coll_d[a] = 2'b00;
          end
        end
`else
        coll_d = res;
`endif
      end
      default: ;
    endcase
  end

  // Address runs one entry ahead so obs_data for entry k arrives in SCAN cycle k.
  assign obs_addr  = (state_q == SCAN) ? k_q + AW'(1) : '0;
  assign collision = coll_q;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;

endmodule
